seq_muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide unit that replaces the single-cycle ALU mul/div path feeding Z/HI/LO.
- Datapath control presents operands and a one-cycle start; the unit iterates one bit per clock, then pulses done with the 2*WIDTH result on hi/lo for the HI/LO register load.
- Supports signed and unsigned modes; flags divide-by-zero.

---
 rtl/seq_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide unit: one bit per clock, sign-corrected result loaded
// into hi/lo with a one-cycle done pulse. Latency is WIDTH+2 edges from start.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_next;

  logic               op_q;
  logic               a_neg;
  logic               b_neg;
  logic               dz_q;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] p;      // mul: product accumulator; div: quotient in low half
  logic [WIDTH:0]     rem;
  logic [CNT_W-1:0]   cnt;

  logic               a_sign;
  logic               b_sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_tmp;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;

  assign state_dbg = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1), so the most negative
  // operand negates without loss.
  always_comb begin
    a_sign   = is_signed & a[WIDTH-1];
    b_sign   = is_signed & b[WIDTH-1];
    a_mag    = a_sign ? (~a + WIDTH'(1)) : a;
    b_mag    = b_sign ? (~b + WIDTH'(1)) : b;
    mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mag_b} : '0);
    div_tmp  = {rem, p[WIDTH-1]};
    div_diff = div_tmp - {2'b00, mag_b};
    div_ge   = ~div_diff[WIDTH+1];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q        <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz_q        <= 1'b0;
      a_raw       <= '0;
      mag_b       <= '0;
      p           <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op_q  <= op;
          a_neg <= a_sign;
          b_neg <= b_sign;
          dz_q  <= op && (b == '0);
          a_raw <= a;
          mag_b <= b_mag;
          p     <= {{WIDTH{1'b0}}, a_mag};
          rem   <= '0;
          cnt   <= CNT_W'(WIDTH);
          busy  <= 1'b1;
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (!op_q) begin
            p <= {mul_sum, p[WIDTH-1:1]};
          end else begin
            rem          <= div_ge ? div_diff[WIDTH:0] : div_tmp[WIDTH:0];
            p[WIDTH-1:0] <= {p[WIDTH-2:0], div_ge};
          end
        end
        S_FIX: begin
          if (!op_q) begin
            if (a_neg ^ b_neg) p <= -p;
          end else begin
            if (a_neg ^ b_neg) p[WIDTH-1:0] <= -p[WIDTH-1:0];
            if (a_neg) rem <= -rem;
          end
        end
        S_DONE: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dz_q;
          if (dz_q) begin
            hi <= a_raw;
            lo <= '1;
          end else if (op_q) begin
            hi <= rem[WIDTH-1:0];
            lo <= p[WIDTH-1:0];
          end else begin
            hi <= p[2*WIDTH-1:WIDTH];
            lo <= p[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit: WIDTH=32 and WIDTH=8 instances, expected results
// queued at issue time and checked by independent monitors on done.
module tb_seq_muldiv_unit;

  localparam int W = 32;

  // clock / reset
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic         start = 1'b0, op = 1'b0, is_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic         busy, done, div_by_zero;
  logic [1:0]   state_dbg;

  logic         start8 = 1'b0, op8 = 1'b0, is_signed8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0, hi8, lo8;
  logic         busy8, done8, div_by_zero8;
  logic [1:0]   state_dbg8;

  seq_muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  seq_muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .op(op8), .is_signed(is_signed8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
    .div_by_zero(div_by_zero8), .state_dbg(state_dbg8)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [16:0]  exp8_q[$];
  int           exp8_cyc_q[$];

  task automatic check(input string name, input logic [128:0] got, input logic [128:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit operands.
  // Returns {div_by_zero, hi[63:0], lo[63:0]}.
  function automatic logic [128:0] model(input int w, input logic o, input logic s,
                                         input logic [63:0] aa, input logic [63:0] bb);
    logic [63:0] mask, ua, ub, prod, uq, ur;
    longint      sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua   = aa & mask;
    ub   = bb & mask;
    sa   = (s && ua[w-1]) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = (s && ub[w-1]) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    if (!o) begin
      if (s) prod = 64'(sa * sb);
      else   prod = ua * ub;
      return {1'b0, (prod >> w) & mask, prod & mask};
    end
    if (ub == 64'd0) return {1'b1, ua, mask};
    if (s) begin
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, 64'(sr) & mask, 64'(sq) & mask};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {1'b0, ur & mask, uq & mask};
  endfunction

  // driver tasks: called at a negedge, return 1 ns after the start edge
  task automatic issue32(input logic o, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [128:0] m;
    m = model(W, o, s, 64'(aa), 64'(bb));
    exp_q.push_back({m[128], m[95:64], m[31:0]});
    op = o; is_signed = s; a = aa; b = bb; start = 1'b1;
    @(posedge clock); #1;
    exp_cyc_q.push_back(cyc + W + 2);
    start = 1'b0;
    op = 1'($urandom); is_signed = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic issue8(input logic o, input logic s, input logic [7:0] aa, input logic [7:0] bb);
    logic [128:0] m;
    m = model(8, o, s, 64'(aa), 64'(bb));
    exp8_q.push_back({m[128], m[71:64], m[7:0]});
    op8 = o; is_signed8 = s; a8 = aa; b8 = bb; start8 = 1'b1;
    @(posedge clock); #1;
    exp8_cyc_q.push_back(cyc + 10);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // returns at the negedge on which done is seen
  task automatic wait_done(input bit narrow);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (narrow ? done8 : done) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL done_timeout: got no done within 100 cycles, expected done (narrow=%0d)", narrow);
  endtask

  // monitors
  int   bcnt32 = 0, bcnt8 = 0;
  logic dprev32 = 1'b0, dprev8 = 1'b0;

  always @(negedge clock) begin
    if (clear) begin
      bcnt32 = 0;
    end else begin
      if (busy) bcnt32++;
      if (dprev32) check("done_pulse32", 129'(done), 129'(0));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done32: got hi=%h lo=%h, expected no done", hi, lo);
        end else begin
          check("result32", 129'({div_by_zero, hi, lo}), 129'(exp_q.pop_front()));
          check("latency32", 129'(cyc), 129'(exp_cyc_q.pop_front()));
          check("busy_cycles32", 129'(bcnt32), 129'(W + 2));
        end
        bcnt32 = 0;
      end
    end
    dprev32 = done;
  end

  always @(negedge clock) begin
    if (clear) begin
      bcnt8 = 0;
    end else begin
      if (busy8) bcnt8++;
      if (dprev8) check("done_pulse8", 129'(done8), 129'(0));
      if (done8) begin
        if (exp8_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done8: got hi=%h lo=%h, expected no done", hi8, lo8);
        end else begin
          check("result8", 129'({div_by_zero8, hi8, lo8}), 129'(exp8_q.pop_front()));
          check("latency8", 129'(cyc), 129'(exp8_cyc_q.pop_front()));
          check("busy_cycles8", 129'(bcnt8), 129'(10));
        end
        bcnt8 = 0;
      end
    end
    dprev8 = done8;
  end

  typedef struct packed {logic o; logic s; logic [W-1:0] a; logic [W-1:0] b;} vec_t;
  vec_t dir[8];

  initial begin
    logic [W-1:0] ra, rb;
    dir[0] = '{1'b0, 1'b0, 32'h0007_8945, 32'h0005_4987};
    dir[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[2] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5};
    dir[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2};
    dir[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    dir[5] = '{1'b1, 1'b0, 32'd100, 32'd7};
    dir[6] = '{1'b1, 1'b0, 32'h1234_5678, 32'd0};
    dir[7] = '{1'b1, 1'b0, 32'd100, 32'd7};

    // reset state while clear is held
    #1;
    check("reset_busy", 129'(busy), 129'(0));
    check("reset_done", 129'(done), 129'(0));
    check("reset_hi", 129'(hi), 129'(0));
    check("reset_lo", 129'(lo), 129'(0));
    check("reset_dbz", 129'(div_by_zero), 129'(0));
    check("reset_busy8", 129'(busy8), 129'(0));
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // directed vectors, issued back to back from the cycle after done
    foreach (dir[i]) begin
      issue32(dir[i].o, dir[i].s, dir[i].a, dir[i].b);
      wait_done(1'b0);
    end

    // start while busy at edge k+5 is ignored
    @(negedge clock);
    issue32(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (5) @(negedge clock);
    op = 1'b1; a = 32'hDEAD_BEEF; b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(1'b0);

    // start coinciding with the done edge is ignored
    @(negedge clock);
    issue32(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    repeat (W + 2) @(negedge clock);
    op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (50) @(negedge clock);

    // clear mid-CALC aborts immediately, no done pulse follows
    op = 1'b0; is_signed = 1'b0; a = 32'h0BAD_F00D; b = 32'h0000_0321; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check("clear_busy", 129'(busy), 129'(0));
    check("clear_done", 129'(done), 129'(0));
    check("clear_hi", 129'(hi), 129'(0));
    check("clear_lo", 129'(lo), 129'(0));
    @(negedge clock);
    #2;
    clear = 1'b0;
    repeat (50) @(negedge clock);
    issue32(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done(1'b0);

    // randomized operations with occasional corner operands
    for (int i = 0; i < 40; i++) begin
      ra = (i % 9 == 4) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      @(negedge clock);
      issue32(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
      wait_done(1'b0);
    end

    // WIDTH=8 instance: directed signed multiply, then randomized
    @(negedge clock);
    issue8(1'b0, 1'b1, 8'hF3, 8'h05);
    wait_done(1'b1);
    issue8(1'b1, 1'b1, 8'h80, 8'hFF);
    wait_done(1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      issue8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
      wait_done(1'b1);
    end

    repeat (5) @(negedge clock);
    check("queue32_drained", 129'(exp_q.size()), 129'(0));
    check("queue8_drained", 129'(exp8_q.size()), 129'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
